// File: rtl/n64_cfg_mailbox_if.sv
// -----------------------------------------------------------------------------
// n64_cfg_mailbox_if
//   N64 PI register access bus between the PI front end and the mailbox.
//
//   n64_request  single-cycle access strobe
//   n64_write    1 = write, 0 = read
//   n64_address  halfword index (0..15)
//   n64_wdata    write data
//   n64_rdata    read data, valid while n64_ack
//   n64_ack      access acknowledge, one cycle after the request
//
//   master: the PI side issuing accesses; slave: the mailbox answering them.
// -----------------------------------------------------------------------------
interface n64_cfg_mailbox_if;
    logic        n64_request;
    logic        n64_write;
    logic [3:0]  n64_address;
    logic [15:0] n64_wdata;
    logic [15:0] n64_rdata;
    logic        n64_ack;

    modport master (
        output n64_request, n64_write, n64_address, n64_wdata,
        input  n64_rdata, n64_ack
    );

    modport slave (
        input  n64_request, n64_write, n64_address, n64_wdata,
        output n64_rdata, n64_ack
    );
endinterface

// File: rtl/n64_cfg_mailbox.sv
// -----------------------------------------------------------------------------
// n64_cfg_mailbox
//   N64-side endpoint of the CPU configuration/command channel. Decodes 16-bit
//   PI register accesses into a status word, a command byte and two 32-bit data
//   words, raises a command request toward the CPU and follows the CPU busy
//   handshake until the command completes. The CPU may write the data words
//   back at any time.
//
//   Register map (halfword index: even = high half, odd = low half)
//     0/1  SR     {cpu_ready, busy, error, timeout, 28'd0}   (idx1 wdata[0]=1 clears error/timeout)
//     2/3  CMD    {24'd0, cmd}                               (idx3 write issues a command)
//     4/5  DATA_0 (high half loads staging, low half commits {staging, wdata})
//     6/7  DATA_1
//     8-15 read 0, writes ignored
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   n64              N64 PI access bus (slave modport)
//   cpu_ready        CPU firmware ready
//   cpu_busy         CPU processing a command
//   cmd              command byte
//   cmd_request      one-cycle command pulse to the CPU
//   data_0, data_1   data words
//   cpu_data_write   CPU write strobe per data word
//   cpu_wdata        CPU write data
//
// Optional feature: define CMD_TIMEOUT_EN to abort a command that spends
// TIMEOUT_CYCLES cycles waiting for the CPU (sets error and timeout).
// -----------------------------------------------------------------------------
module n64_cfg_mailbox #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_500_000
) (
    input  logic                    clk,
    input  logic                    reset,
    n64_cfg_mailbox_if.slave        n64,
    input  logic                    cpu_ready,
    input  logic                    cpu_busy,
    output logic [7:0]              cmd,
    output logic                    cmd_request,
    output logic [31:0]             data_0,
    output logic [31:0]             data_1,
    input  logic [1:0]              cpu_data_write,
    input  logic [31:0]             cpu_wdata
);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_REQUEST     = 2'd1;
    localparam logic [1:0] ST_WAIT_ACCEPT = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE   = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [15:0] staging;
    logic        error;
    logic        timeout;
    logic        busy;

    logic        n64_wr;
    logic        is_data;
    logic        data_wr_ok;
    logic        data_wr_err;
    logic        cmd_wr;
    logic        cmd_accept;
    logic        cmd_reject;
    logic        sr_clear;
    logic        ready_lost;
    logic        timed_out;
    logic        timeout_hit;
    logic        err_set;
    logic        err_clr;
    logic        commit_0;
    logic        commit_1;
    logic [31:0] rd_word;
    logic [15:0] rd_half;

    // busy is taken from the current state, so a command written in the
    // cycle the FSM returns to IDLE is still rejected.
    assign busy = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    assign n64_wr      = n64.n64_request && n64.n64_write;
    assign is_data     = (n64.n64_address[3:2] == 2'b01);
    assign data_wr_ok  = n64_wr && is_data && !busy;
    assign data_wr_err = n64_wr && is_data && busy;
    assign cmd_wr      = n64_wr && (n64.n64_address == 4'd3);
    assign cmd_accept  = cmd_wr && !busy && cpu_ready;
    assign cmd_reject  = cmd_wr && !cmd_accept;
    assign sr_clear    = n64_wr && (n64.n64_address == 4'd1) && n64.n64_wdata[0];
    assign commit_0    = data_wr_ok && (n64.n64_address == 4'd5);
    assign commit_1    = data_wr_ok && (n64.n64_address == 4'd7);

    // A new error always wins over a same-cycle clear.
    assign err_set = data_wr_err || cmd_reject || ready_lost || timed_out;
    assign err_clr = sr_clear || cmd_accept;

    // ------------------------------------------------------------------
    // Optional command timeout
    // ------------------------------------------------------------------
`ifdef CMD_TIMEOUT_EN
    logic [23:0] wait_count;
    logic        in_wait;

    assign in_wait     = (state == ST_WAIT_ACCEPT) || (state == ST_WAIT_DONE);
    assign timeout_hit = in_wait && (wait_count == TIMEOUT_CYCLES - 24'd1);

    // Counter is zero on the first WAIT_ACCEPT cycle, so the abort happens
    // after exactly TIMEOUT_CYCLES waiting cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_count <= '0;
        end else if (state == ST_REQUEST) begin
            wait_count <= '0;
        end else if (in_wait) begin
            wait_count <= wait_count + 24'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        ready_lost = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_accept) state_next = ST_REQUEST;
            end
            ST_REQUEST: begin
                state_next = ST_WAIT_ACCEPT;
            end
            ST_WAIT_ACCEPT, ST_WAIT_DONE: begin
                if (!cpu_ready) begin
                    ready_lost = 1'b1;
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    timed_out  = 1'b1;
                    state_next = ST_IDLE;
                end else if (state == ST_WAIT_ACCEPT && cpu_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (state == ST_WAIT_DONE && !cpu_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rd_word = '0;
        case (n64.n64_address[3:1])
            3'd0:    rd_word = {cpu_ready, busy, error, timeout, 28'd0};
            3'd1:    rd_word = {24'd0, cmd};
            3'd2:    rd_word = data_0;
            3'd3:    rd_word = data_1;
            default: rd_word = '0;
        endcase
        rd_half = n64.n64_address[0] ? rd_word[15:0] : rd_word[31:16];
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            n64.n64_ack   <= 1'b0;
            n64.n64_rdata <= '0;
            cmd         <= '0;
            cmd_request <= 1'b0;
            data_0      <= '0;
            data_1      <= '0;
            staging     <= '0;
            error       <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state         <= state_next;
            n64.n64_ack   <= n64.n64_request;
            n64.n64_rdata <= (n64.n64_request && !n64.n64_write) ? rd_half : 16'd0;

            // Registered off REQUEST: the pulse lands two cycles after the
            // accepted command write, for exactly one cycle.
            cmd_request <= (state == ST_REQUEST);

            if (cmd_accept) cmd <= n64.n64_wdata[7:0];

            if (data_wr_ok && !n64.n64_address[0]) staging <= n64.n64_wdata;

            // CPU write-back takes priority over an N64 commit to the same word.
            if (cpu_data_write[0])  data_0 <= cpu_wdata;
            else if (commit_0)      data_0 <= {staging, n64.n64_wdata};

            if (cpu_data_write[1])  data_1 <= cpu_wdata;
            else if (commit_1)      data_1 <= {staging, n64.n64_wdata};

            if (err_set)            error <= 1'b1;
            else if (err_clr)       error <= 1'b0;

            if (timed_out)          timeout <= 1'b1;
            else if (err_clr)       timeout <= 1'b0;
        end
    end

endmodule
